recon_error_accum: RTL and testbench
====================================

Name: recon_error_accum

Overview:
- Downstream consumer of the forward pass: takes the 9 decoder outputs (out1..out9, Q8.8) and the 9 original inputs (x1..x9, Q8.8).
- Produces per-pixel reconstruction error e_i = y_i - x_i for the backward stage, plus a sum-of-squared-error (SSE) scalar.
- Uses one serial square/accumulate datapath over N cycles behind a valid/ready handshake.

Parameters:
- WIDTH, 16: data word width, signed two's complement.
- FRAC, 8: fractional bits (Q8.8).
- N, 9: number of elements per frame.
- ACC_W, 24: SSE accumulator width, unsigned.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- in_valid  in  1  frame present on y_flat/x_flat.
- in_ready  out  1  block can accept a frame.
- y_flat  in  N*WIDTH  decoder outputs; element i at [i*WIDTH +: WIDTH].
- x_flat  in  N*WIDTH  target inputs, same packing.
- out_valid  out  1  results valid.
- out_ready  in  1  consumer accepts results.
- err_flat  out  N*WIDTH  per-element error y_i - x_i, same packing.
- sse  out  WIDTH  sum over i of e_i*e_i, Q8.8, unsigned value in signed word.

Behaviour:
- Reset (rst=0, async) applies: state=IDLE, in_ready=1, out_valid=0, err_flat=0, sse=0, accumulator=0, idx=0. Release is synchronous to clk.
- Three states:
  - IDLE: in_ready=1. On the edge with in_valid&in_ready: capture y_flat/x_flat into internal registers, clear the accumulator, set idx=0, go to ACCUM.
  - ACCUM: in_ready=0. Each edge processes element idx:
    - diff = y - x, computed in WIDTH+1 bits, reduced to WIDTH (see the optional feature).
    - diff is written to err_flat[idx].
    - sq = (diff*diff) >>> FRAC, 2*WIDTH-bit product, truncated.
    - acc += sq.
    - idx increments. At idx=N-1, go to DONE and set out_valid=1 on that same edge.
  - DONE: out_valid=1. sse = min(acc, 2^(WIDTH-1)-1), always saturated. err_flat and sse are held stable. On the edge with out_valid&out_ready: out_valid=0, go to IDLE. in_ready returns to 1 after that edge, so there is no same-cycle re-accept.
- Latency: out_valid rises N edges after the accepting edge (9 cycles at default). Throughput is one frame per N+2 cycles minimum.
- Inputs change while busy: ignored. Captured copies are used.
- in_valid held high in DONE: not accepted until IDLE.
- out_ready high before out_valid: no effect.
- err_flat entries not yet processed in ACCUM hold their previous-frame values. Consumers read only while out_valid=1.
- Accumulator uses unsigned ACC_W bits and saturates at 2^ACC_W-1. It never wraps.
- Reset asserted mid-ACCUM or in DONE: immediate return to reset values; the partial frame is discarded.

Optional Feature:
- Macro: RECON_SAT_EN.
- Defined: diff saturates to [0x8000, 0x7FFF] when the WIDTH+1-bit result overflows.
- Undefined: diff is the low WIDTH bits (wrap-around).
- All other behaviour is identical in both builds, including SSE output saturation.

Test Plan:
- Identity: y_flat = x_flat = {0x0100,0x0000} alternating -> after 9 cycles out_valid=1, all err=0x0000, sse=0x0000.
- Half error: all x=0x0100, all y=0x0080 -> every err=0xFF80; sq=0x0040 each; sse=0x0240 (2.25).
- Backpressure: out_ready=0 for 20 cycles after out_valid -> out_valid, err_flat and sse stable; in_ready=0 throughout. One cycle of out_ready -> IDLE, then in_ready=1 on the next cycle.
- Overflow: x0=0x7FFF, y0=0x8000, rest zero:
  - With RECON_SAT_EN: err0=0x8000, sse=0x7FFF (saturated).
  - Without RECON_SAT_EN: err0=0x0001, sse=0x0000.
- Reset mid-op: assert rst=0 at cycle 4 of ACCUM -> out_valid=0, in_ready=1, sse=0 immediately. A fresh frame then completes with correct results.
- Back-to-back: in_valid held high with two different frames -> second frame accepted only after the first handshake completes. Both sse values are correct.

Source files
------------

// File: rtl/recon_error_accum.sv
// Reconstruction error y-x per element plus saturated Q8.8 sum of squares.
// Define RECON_SAT_EN to saturate each difference instead of wrapping it.
module recon_error_accum #(
  parameter int WIDTH = 16,
  parameter int FRAC  = 8,
  parameter int N     = 9,
  parameter int ACC_W = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N*WIDTH-1:0]   y_flat,
  input  logic [N*WIDTH-1:0]   x_flat,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N*WIDTH-1:0]   err_flat,
  output logic [WIDTH-1:0]     sse
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [N*WIDTH-1:0]      y_q;
  logic [N*WIDTH-1:0]      x_q;
  logic [IW-1:0]           idx;
  logic [ACC_W-1:0]        acc;
  logic [ACC_W-1:0]        acc_nx;
  logic signed [WIDTH-1:0] ye;
  logic signed [WIDTH-1:0] xe;
  logic signed [WIDTH-1:0] diff;
  logic signed [2*WIDTH-1:0] prod;
  logic signed [2*WIDTH-1:0] sq;
  logic [2*WIDTH:0]        sum;
  logic [WIDTH-1:0]        sse_nx;
  logic                    last;
  logic                    take;
  logic                    give;

  assign ye = y_q[idx*WIDTH +: WIDTH];
  assign xe = x_q[idx*WIDTH +: WIDTH];

`ifdef RECON_SAT_EN
  logic signed [WIDTH:0] dw;
  assign dw = {ye[WIDTH-1], ye} - {xe[WIDTH-1], xe};
  // Top two bits disagree only when the true difference left WIDTH range.
  always_comb begin
    diff = dw[WIDTH-1:0];
    if (dw[WIDTH] != dw[WIDTH-1]) begin
      diff = dw[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}}
                       : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end
`else
  assign diff = ye - xe;
`endif

  assign prod = diff * diff;
  assign sq   = prod >>> FRAC;
  assign sum  = {{(2*WIDTH+1-ACC_W){1'b0}}, acc}
              + {1'b0, sq};
  assign acc_nx = (|sum[2*WIDTH:ACC_W]) ? '1 : sum[ACC_W-1:0];
  assign sse_nx = (|acc_nx[ACC_W-1:WIDTH-1])
                ? {1'b0, {(WIDTH-1){1'b1}}}
                : acc_nx[WIDTH-1:0];

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign last = (idx == IW'(N-1));
  assign take = in_valid & in_ready;
  assign give = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (take) state_nx = ACCUM;
      ACCUM:   if (last) state_nx = DONE;
      DONE:    if (give) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      y_q      <= '0;
      x_q      <= '0;
      idx      <= '0;
      acc      <= '0;
      err_flat <= '0;
      sse      <= '0;
    end else begin
      if (state == IDLE && take) begin
        y_q <= y_flat;
        x_q <= x_flat;
        acc <= '0;
        idx <= '0;
      end
      if (state == ACCUM) begin
        err_flat[idx*WIDTH +: WIDTH] <= diff;
        acc <= acc_nx;
        idx <= last ? '0 : idx + 1'b1;
        if (last) sse <= sse_nx;
      end
    end
  end

endmodule

// File: tb/tb_recon_error_accum.sv
// Directed frames with queued expectations and a decoupled output monitor.
module tb_recon_error_accum;

  localparam int W = 16;
  localparam int N = 9;

  typedef struct packed {
    logic [N*W-1:0] err;
    logic [W-1:0]   sse;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [N*W-1:0] y_flat;
  logic [N*W-1:0] x_flat;
  logic           out_valid;
  logic           out_ready;
  logic [N*W-1:0] err_flat;
  logic [W-1:0]   sse;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_pop = 0;

  recon_error_accum dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .y_flat(y_flat),
    .x_flat(x_flat),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .err_flat(err_flat),
    .sse(sse)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name,
                     input logic [N*W-1:0] act,
                     input logic [N*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got sse %h expected none", sse);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("err_flat", err_flat, e.err);
        chk("sse", {{(N*W-W){1'b0}}, sse}, {{(N*W-W){1'b0}}, e.sse});
        last_pop = cyc;
      end
    end
  end

  function automatic logic [N*W-1:0] rep(input logic [W-1:0] v);
    logic [N*W-1:0] r;
    for (int i = 0; i < N; i++) r[i*W +: W] = v;
    return r;
  endfunction

  function automatic logic [N*W-1:0] setel(input logic [N*W-1:0] f,
                                           input int i,
                                           input logic [W-1:0] v);
    logic [N*W-1:0] r;
    r = f;
    r[i*W +: W] = v;
    return r;
  endfunction

  task automatic issue(input logic [N*W-1:0] y,
                       input logic [N*W-1:0] x,
                       input exp_t e,
                       input bit push,
                       input bit keep,
                       output int acc_at);
    bit ok;
    bit rdy;
    ok = 1'b0;
    if (push) q.push_back(e);
    in_valid = 1'b1;
    y_flat = y;
    x_flat = x;
    for (int n = 0; n < 100; n++) begin
      rdy = in_ready;
      @(posedge clk);
      #1;
      if (rdy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got no accept expected accept");
    end
    acc_at = cyc;
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      if (q.size() == 0 && in_ready) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got pending %0d expected 0", q.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int at;
    int at_b;
    int lat;
    int bad;
    logic [N*W-1:0] y;
    logic [N*W-1:0] x;

    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    y_flat = '0;
    x_flat = '0;
    #12;
    chk("rst_in_ready", N*W'(in_ready), N*W'(1));
    chk("rst_out_valid", N*W'(out_valid), '0);
    chk("rst_sse", N*W'(sse), '0);
    chk("rst_err", err_flat, '0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    y = '0;
    for (int i = 0; i < N; i += 2) y = setel(y, i, 16'h0100);
    e.err = '0;
    e.sse = 16'h0000;
    issue(y, y, e, 1'b1, 1'b0, at);
    wait_out(lat);
    chk("identity_latency", N*W'(lat), N*W'(9));
    drain();

    out_ready = 1'b0;
    e.err = rep(16'hFF80);
    e.sse = 16'h0240;
    issue(rep(16'h0080), rep(16'h0100), e, 1'b1, 1'b0, at);
    wait_out(lat);
    chk("half_latency", N*W'(lat), N*W'(9));
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
          err_flat !== rep(16'hFF80) || sse !== 16'h0240)
        bad++;
      @(posedge clk);
      #1;
    end
    chk("bp_hold_bad_cycles", N*W'(bad), '0);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_out_valid", N*W'(out_valid), '0);
    chk("bp_release_in_ready", N*W'(in_ready), N*W'(1));
    drain();

    y = setel('0, 0, 16'h8000);
    x = setel('0, 0, 16'h7FFF);
`ifdef RECON_SAT_EN
    e.err = setel('0, 0, 16'h8000);
    e.sse = 16'h7FFF;
`else
    e.err = setel('0, 0, 16'h0001);
    e.sse = 16'h0000;
`endif
    issue(y, x, e, 1'b1, 1'b0, at);
    drain();

    y = '0;
    for (int i = 0; i < 4; i++) y = setel(y, i, 16'h8000);
    e.err = y;
    e.sse = 16'h7FFF;
    issue(y, '0, e, 1'b1, 1'b0, at);
    drain();

    e.err = rep(16'h1000);
    e.sse = 16'h7FFF;
    issue(rep(16'h1000), '0, e, 1'b1, 1'b0, at);
    drain();

    issue(rep(16'h0100), '0, e, 1'b0, 1'b0, at);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("midrst_out_valid", N*W'(out_valid), '0);
    chk("midrst_in_ready", N*W'(in_ready), N*W'(1));
    chk("midrst_sse", N*W'(sse), '0);
    chk("midrst_err", err_flat, '0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    e.err = rep(16'h0100);
    e.sse = 16'h0900;
    issue(rep(16'h0100), '0, e, 1'b1, 1'b0, at);
    wait_out(lat);
    chk("fresh_latency", N*W'(lat), N*W'(9));
    drain();

    e.err = rep(16'h0200);
    e.sse = 16'h2400;
    issue(rep(16'h0200), '0, e, 1'b1, 1'b1, at);
    y = setel('0, 0, 16'h0300);
    e.err = y;
    e.sse = 16'h0900;
    issue(y, '0, e, 1'b1, 1'b0, at_b);
    chk("b2b_accept_cycle", N*W'(at_b), N*W'(last_pop + 2));
    drain();

    chk("queue_empty", N*W'(q.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
